// File: rtl/axis_video_pattern_src.sv
// axis_video_pattern_src: AXI4-Stream video frame generator with SOF/EOL framing, gaps and backpressure
module axis_video_pattern_src #(
  parameter int DATA_WIDTH = 64,
  parameter int PIX_PER_BEAT = 2,
  parameter int DIM_BITS = 12,
  parameter int LINE_GAP = 2,
  parameter int FRAME_GAP = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic                  SW_RESET,
  input  logic                  enable,
  input  logic [DIM_BITS-1:0]   beats_per_line,
  input  logic [DIM_BITS-1:0]   lines_per_frame,
  input  logic [1:0]            pattern_sel,
  input  logic [31:0]           solid_color,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  busy,
  output logic                  frame_done
);
  typedef enum logic [1:0] {IDLE, STREAM, LGAP, FGAP} state_t;
  state_t state;
  logic [DIM_BITS-1:0] bpl, lpf, x, y, nx, ny;
  logic [1:0] ps;
  logic [31:0] sc;
  logic [15:0] gap;
  logic acc, eol, eof, start, frame_end, launch, stop;
  logic [DATA_WIDTH-1:0] first_beat, next_beat;
  function automatic logic [DATA_WIDTH-1:0] beat(input logic [DIM_BITS-1:0] bx, input logic [DIM_BITS-1:0] by,
                                                 input logic [1:0] p, input logic [31:0] c);
    logic [15:0] px, py;
    beat = '0;
    py = 16'(by);
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      px = 16'(bx) * 16'(PIX_PER_BEAT) + 16'(k);
      beat[32*k +: 32] = p == 2'd0 ? {py, px} : p == 2'd1 ? c : p == 2'd2 ? {32{px[3] ^ py[3]}} : {4{px[7:0]}};
    end
  endfunction
  assign acc = aclken & m_axis_video_tvalid & m_axis_video_tready;
  assign eol = x == bpl - 1'b1;
  assign eof = eol & (y == lpf - 1'b1);
  assign start = enable & |beats_per_line & |lines_per_frame;
  assign nx = eol ? '0 : x + 1'b1;
  assign ny = eol ? y + 1'b1 : y;
  assign next_beat = beat(nx, ny, ps, sc);
  assign first_beat = beat({DIM_BITS{1'b0}}, {DIM_BITS{1'b0}}, pattern_sel, solid_color);
  assign frame_end = (state == FGAP && gap == '0) || (state == STREAM && acc && eof && FRAME_GAP == 0);
  assign launch = start & (state == IDLE | frame_end);
  assign stop = ~start & frame_end;
  assign frame_done = acc & eof & aresetn & ~SW_RESET;
  always_ff @(posedge aclk)
    if (!aresetn || SW_RESET) begin
      state <= IDLE;
      {m_axis_video_tvalid, m_axis_video_tuser, m_axis_video_tlast, busy} <= '0;
      m_axis_video_tdata <= '0;
      {x, y, bpl, lpf} <= '0;
      ps <= '0;
      sc <= '0;
      gap <= '0;
    end else if (aclken) begin
      case (state)
        STREAM:
          if (acc && !eof) begin
            x <= nx;
            y <= ny;
            m_axis_video_tdata <= next_beat;
            m_axis_video_tuser <= 1'b0;
            m_axis_video_tlast <= nx == bpl - 1'b1;
            if (eol && LINE_GAP > 0) begin
              state <= LGAP;
              m_axis_video_tvalid <= 1'b0;
              gap <= 16'(LINE_GAP - 1);
            end
          end else if (acc && FRAME_GAP > 0) begin
            state <= FGAP;
            {m_axis_video_tvalid, m_axis_video_tuser, m_axis_video_tlast} <= '0;
            gap <= 16'(FRAME_GAP - 1);
          end
        LGAP:
          if (gap == '0) begin
            state <= STREAM;
            m_axis_video_tvalid <= 1'b1;
          end else gap <= gap - 1'b1;
        FGAP: if (gap != '0) gap <= gap - 1'b1;
        default: ;
      endcase
      if (launch) begin
        state <= STREAM;
        busy <= 1'b1;
        m_axis_video_tvalid <= 1'b1;
        m_axis_video_tuser <= 1'b1;
        m_axis_video_tlast <= beats_per_line == 1;
        m_axis_video_tdata <= first_beat;
        x <= '0;
        y <= '0;
        bpl <= beats_per_line;
        lpf <= lines_per_frame;
        ps <= pattern_sel;
        sc <= solid_color;
      end else if (stop) begin
        state <= IDLE;
        {m_axis_video_tvalid, m_axis_video_tuser, m_axis_video_tlast, busy} <= '0;
      end
    end
endmodule

// File: tb/tb_axis_video_pattern_src.sv
// tb_axis_video_pattern_src: random and directed checks of the video source against a coordinate-level model
module tb_axis_video_pattern_src;
  logic clk = 0, aresetn, aclken, sw_reset, enable, tready;
  logic [11:0] bpl_in, lpf_in;
  logic [1:0] ps_in;
  logic [31:0] sc_in;
  logic [63:0] tdata;
  logic tvalid, tuser, tlast, busy, frame_done;
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] log_data[$];
  bit log_user[$], log_last[$], log_fd[$];
  int log_cyc[$];
  bit in_frame = 0, hold = 0, h_user, h_last;
  logic [63:0] h_data;
  int mx, my, c_bpl, c_lpf, c_ps;
  logic [31:0] c_sc;

  axis_video_pattern_src #(.DATA_WIDTH(64), .PIX_PER_BEAT(2), .DIM_BITS(12), .LINE_GAP(2), .FRAME_GAP(4)) dut (
    .aclk(clk), .aresetn(aresetn), .aclken(aclken), .SW_RESET(sw_reset), .enable(enable),
    .beats_per_line(bpl_in), .lines_per_frame(lpf_in), .pattern_sel(ps_in), .solid_color(sc_in),
    .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model_beat(input int x, input int y, input int p, input logic [31:0] c);
    logic [63:0] r;
    logic [31:0] v;
    int px;
    r = 0;
    for (int k = 0; k < 2; k++) begin
      px = x * 2 + k;
      if (p == 0) v = 32'(y * 65536 + px);
      else if (p == 1) v = c;
      else if (p == 2) v = ((px / 8) % 2 != (y / 8) % 2) ? 32'hFFFF_FFFF : 32'h0;
      else v = 32'(px % 256) * 32'h0101_0101;
      r[32*k +: 32] = v;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic acc, efd;
    acc = aclken && tvalid && tready && aresetn && !sw_reset;
    efd = 0;
    if (hold) begin
      check("hold_tvalid", tvalid, 1);
      check("hold_tdata", tdata, h_data);
      check("hold_tuser", tuser, h_user);
      check("hold_tlast", tlast, h_last);
    end
    if (acc) begin
      if (!in_frame) begin
        c_bpl = int'(bpl_in); c_lpf = int'(lpf_in); c_ps = int'(ps_in); c_sc = sc_in;
        mx = 0; my = 0; in_frame = 1;
      end
      check("tdata", tdata, model_beat(mx, my, c_ps, c_sc));
      check("tuser", tuser, mx == 0 && my == 0);
      check("tlast", tlast, mx == c_bpl - 1);
      efd = (mx == c_bpl - 1) && (my == c_lpf - 1);
      log_data.push_back(tdata); log_user.push_back(tuser); log_last.push_back(tlast);
      log_fd.push_back(frame_done); log_cyc.push_back(cyc);
      mx++;
      if (mx == c_bpl) begin
        mx = 0; my++;
        if (my == c_lpf) in_frame = 0;
      end
    end
    check("frame_done", frame_done, efd);
    if (!aresetn || sw_reset) in_frame = 0;
    hold = tvalid && !acc && aresetn && !sw_reset;
    h_data = tdata; h_user = tuser; h_last = tlast;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clear_log();
    log_data.delete(); log_user.delete(); log_last.delete(); log_fd.delete(); log_cyc.delete();
  endtask
  task automatic wait_log(input int n, input int budget);
    for (int t = 0; t < budget && log_data.size() < n; t++) step(1);
    if (log_data.size() < n) check("wait_beats_timeout", log_data.size(), n);
  endtask
  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget && busy; t++) step(1);
    check("return_to_idle", busy, 0);
  endtask
  task automatic set_cfg(input int b, input int l, input int p, input logic [31:0] c);
    bpl_in = 12'(b); lpf_in = 12'(l); ps_in = 2'(p); sc_in = c;
  endtask

  initial begin
    int nt;
    aresetn = 0; aclken = 1; sw_reset = 0; enable = 1; tready = 1;
    set_cfg(4, 2, 0, 0);
    step(2);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_tdata", tdata, 0);
    clear_log();
    aresetn = 1;
    step(1);
    check("first_beat_latency", tvalid, 1);
    check("first_beat_tuser", tuser, 1);
    enable = 0;
    wait_log(8, 100);
    wait_idle(50);
    check("t1_beats", log_data.size(), 8);
    check("t1_beat0", log_data[0], 64'h0000_0001_0000_0000);
    check("t1_beat0_user", log_user[0], 1);
    check("t1_beat3", log_data[3], 64'h0000_0007_0000_0006);
    check("t1_beat3_last", log_last[3], 1);
    check("t1_line_gap", log_cyc[4] - log_cyc[3], 3);
    check("t1_beat4", log_data[4], 64'h0001_0001_0001_0000);
    check("t1_fd7", log_fd[7], 1);
    check("t1_fd6", log_fd[6], 0);

    clear_log();
    set_cfg(8, 3, 0, 0);
    enable = 1;
    for (int t = 0; t < 3000 && (log_data.size() < 24 || busy); t++) begin
      tready = $urandom_range(0, 99) < 30;
      step(1);
      if (log_data.size() >= 1) enable = 0;
      if (log_data.size() >= 5) set_cfg(3, 1, 2, 32'h1234_5678);
    end
    tready = 1;
    wait_idle(50);
    check("bp_beats", log_data.size(), 24);
    check("bp_beat9", log_data[9], 64'h0001_0003_0001_0002);

    for (int i = 0; i < 6; i++) begin
      clear_log();
      set_cfg($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 3), $urandom);
      nt = int'(bpl_in) * int'(lpf_in);
      enable = 1;
      for (int t = 0; t < 3000 && (log_data.size() < 1 || busy); t++) begin
        tready = $urandom_range(0, 99) < 60;
        aclken = $urandom_range(0, 99) < 80;
        step(1);
        if (log_data.size() >= 1) enable = 0;
      end
      aclken = 1; tready = 1;
      wait_idle(50);
      check("rand_beats", log_data.size(), nt);
    end

    clear_log();
    set_cfg(8, 1, 0, 0);
    enable = 1;
    wait_log(3, 50);
    enable = 0;
    aclken = 0;
    h_data = tdata;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("gated_tvalid", tvalid, 1);
      check("gated_tdata", tdata, 64'h0000_0007_0000_0006);
    end
    aclken = 1;
    wait_idle(50);
    check("gated_beat3", log_data[3], 64'h0000_0007_0000_0006);
    check("gated_stall", log_cyc[3] - log_cyc[2], 6);
    check("gated_beats", log_data.size(), 8);

    clear_log();
    set_cfg(16, 4, 0, 0);
    enable = 1;
    wait_log(3, 50);
    sw_reset = 1;
    step(1);
    sw_reset = 0;
    check("swr_tvalid", tvalid, 0);
    check("swr_busy", busy, 0);
    wait_log(4, 50);
    enable = 0;
    check("swr_sof", log_user[3], 1);
    check("swr_first", log_data[3], 64'h0000_0001_0000_0000);
    wait_idle(300);
    check("swr_beats", log_data.size(), 67);

    clear_log();
    set_cfg(1, 1, 1, 32'hDEAD_BEEF);
    enable = 1;
    wait_log(1, 50);
    enable = 0;
    wait_idle(50);
    check("deg_beats", log_data.size(), 1);
    check("deg_data", log_data[0], 64'hDEAD_BEEF_DEAD_BEEF);
    check("deg_user", log_user[0], 1);
    check("deg_last", log_last[0], 1);
    check("deg_fd", log_fd[0], 1);
    set_cfg(0, 3, 0, 0);
    enable = 1;
    for (int i = 0; i < 6; i++) begin step(1); check("zero_bpl_busy", busy, 0); end
    set_cfg(3, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin step(1); check("zero_lpf_busy", busy, 0); end
    enable = 0;
    check("zero_dims_beats", log_data.size(), 1);

    clear_log();
    set_cfg(2, 2, 3, 0);
    enable = 1;
    wait_log(6, 100);
    set_cfg(2, 2, 0, 0);
    wait_log(9, 100);
    enable = 0;
    wait_idle(100);
    nt = 0;
    foreach (log_user[i]) nt += log_user[i];
    check("cont_beats", log_data.size(), 12);
    check("cont_sof_count", nt, 3);
    check("cont_line_gap", log_cyc[2] - log_cyc[1], 3);
    check("cont_frame_gap1", log_cyc[4] - log_cyc[3], 5);
    check("cont_frame_gap2", log_cyc[8] - log_cyc[7], 5);
    check("cont_ramp", log_data[1], 64'h0303_0303_0202_0202);
    check("cont_relatch", log_data[8], 64'h0000_0001_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_video_pattern_src.md
Name: axis_video_pattern_src

Overview:
AXI4-Stream video master that generates complete frames for the Keystone core's slave video input. It emits 64-bit beats with tuser marking start-of-frame (SOF) and tlast marking end-of-line (EOL), and fully honours tready backpressure. It is the transmit end of the stream interface that Keystone receives. It is used as an on-chip test source and as the bench driver for Keystone.

Parameters:
DATA_WIDTH, 64, tdata width in bits; must equal PIX_PER_BEAT*32.
PIX_PER_BEAT, 2, 32-bit pixels per beat; lane k occupies bits [32k+31:32k].
DIM_BITS, 12, width of the line-length and frame-height configuration fields.
LINE_GAP, 2, idle cycles (tvalid low) inserted after each line; 0 allowed.
FRAME_GAP, 4, idle cycles after the last line before the next SOF; 0 allowed.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
aclken  in  1  clock enable; when low, all state and outputs hold
SW_RESET  in  1  synchronous soft reset, active-high; acts regardless of aclken
enable  in  1  start/continue frame generation
beats_per_line  in  DIM_BITS  line length in beats
lines_per_frame  in  DIM_BITS  frame height in lines
pattern_sel  in  2  0=coordinate, 1=solid, 2=checker, 3=ramp
solid_color  in  32  pixel value used when pattern_sel=1
m_axis_video_tdata  out  DATA_WIDTH  pixel data
m_axis_video_tvalid  out  1  beat valid
m_axis_video_tready  in  1  downstream ready
m_axis_video_tuser  out  1  SOF; high on first beat of a frame only
m_axis_video_tlast  out  1  EOL; high on last beat of each line
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when the final beat of a frame is accepted

Behaviour:
- Reset and SW_RESET: if aresetn=0 or SW_RESET=1 at the aclk edge, the block enters IDLE. tvalid, tuser, tlast, busy and frame_done go to 0, tdata to 0, and counters clear. SW_RESET mid-frame aborts immediately with no tlast; the truncated frame is acceptable because the sink resyncs on the next tuser.
- Handshake: a beat is accepted when aclken & tvalid & tready are all 1.
- Once tvalid is high, tdata, tuser and tlast hold stable until the beat is accepted.
- tvalid never drops without an accept, except on reset or SW_RESET.
- tready is never required before tvalid is asserted.
- aclken=0 freezes state, counters and outputs. frame_done is a pulse in enabled cycles only.
- FSM states: IDLE, STREAM, LGAP, FGAP.
  - IDLE: if enable=1 and both dimensions are nonzero, latch beats_per_line, lines_per_frame, pattern_sel and solid_color, then go to STREAM with x=0, y=0. Zero dimensions keep the block in IDLE.
  - STREAM: tvalid=1. On accept, x increments.
    - On accepting the last beat of a line that is not the last line: x=0, y++, then go to LGAP (LINE_GAP>0) or stay in STREAM.
    - On accepting the last beat of the last line: pulse frame_done, then go to FGAP (FRAME_GAP>0) or to the re-check described under FGAP.
  - LGAP: tvalid=0 for exactly LINE_GAP enabled cycles, then STREAM.
  - FGAP: tvalid=0 for FRAME_GAP enabled cycles. Then, if enable=1 and dimensions are nonzero, re-latch the config and return to STREAM with a new SOF; otherwise go to IDLE.
- Latency: the first beat of a frame has tvalid high on the cycle after the IDLE edge that sees enable=1.
- Back-to-back: with tready held high and LINE_GAP=0, one beat is accepted per cycle across line boundaries.
- Config changes mid-frame have no effect until the next latch.
- Dropping enable mid-frame has no effect; the current frame completes.
- tuser=1 only when x=0 and y=0. tlast=1 only when x=beats_per_line-1.
- Pixel coordinate for lane k: px = x*PIX_PER_BEAT + k; py = y. Coordinates use DIM_BITS+1 bits internally, zero-extended to 16 bits.
- Pixel value by pattern_sel:
  - 0 (coordinate): {py[15:0], px[15:0]}.
  - 1 (solid): solid_color.
  - 2 (checker): 32'hFFFFFFFF if px[3]^py[3], else 32'h0.
  - 3 (ramp): {4{px[7:0]}}; px wraps modulo 256.
- Single-beat line (beats_per_line=1): tuser and tlast are both high on the first beat. Single-line frame: frame_done pulses with the first line's tlast.

Test Plan:
- Reset state: hold aresetn=0 for 2 cycles with enable=1 → tvalid=0, busy=0, tdata=0. Release with beats_per_line=4, lines_per_frame=2, pattern 0, tready=1 → 8 beats. Beat 0 tdata=64'h0000_0001_0000_0000, tuser=1. Beat 3 tlast=1, tdata=64'h0000_0007_0000_0006. LINE_GAP gap of 2 cycles. Beat 4 tdata=64'h0001_0001_0001_0000. frame_done pulses with beat 7.
- Backpressure: random tready at 30% with pattern 0 → tdata/tuser/tlast stable while tvalid=1 and tready=0; the accepted sequence equals the no-backpressure sequence.
- aclken gating: drop aclken for 5 cycles mid-line with tready=1 → no beat is accepted, outputs are unchanged, and the stream resumes at the same x.
- SW_RESET mid-frame: assert at beat 3 of a 16x4 frame → tvalid=0 on the next cycle. With enable=1, the next frame starts with tuser=1 and tdata of coordinate (0,0).
- Degenerate dimensions: beats_per_line=1, lines_per_frame=1, pattern 1, solid_color=32'hDEADBEEF → a single beat 64'hDEADBEEF_DEADBEEF with tuser=1, tlast=1 and frame_done. Dimensions 0 → busy stays 0.
- Continuous mode: enable held at 1 with a 2x2 frame → frames repeat separated by exactly FRAME_GAP=4 idle cycles. tuser appears once per frame; pattern 3 lane bytes equal px.
